// File: rtl/ahb_gpio_irq_pkg.sv
// rtl/ahb_gpio_irq_pkg.sv - shared offsets, HTRANS encodings and parity helper for the AHB GPIO slave
package ahb_gpio_pkg;

  localparam logic [7:0] DATA_OFS  = 8'h00;
  localparam logic [7:0] DIR_OFS   = 8'h04;
  localparam logic [7:0] IEN_OFS   = 8'h08;
  localparam logic [7:0] IPOL_OFS  = 8'h0C;
  localparam logic [7:0] ISTAT_OFS = 8'h10;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  // odd=1 yields the bit that makes the total count of ones odd
  function automatic logic parity(input logic [31:0] d, input logic odd);
    return odd ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/ahb_gpio_irq_if.sv
// rtl/ahb_gpio_irq_if.sv - AHB-Lite slave bus bundle for the GPIO block
interface ahb_gpio_irq_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRDATA
  );
endinterface

// File: rtl/ahb_gpio_irq_sync_edge.sv
// rtl/ahb_gpio_irq_sync_edge.sv - two-flop input synchroniser with polarity-selected edge detect
module gpio_sync_edge #(
  parameter int WIDTH = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [WIDTH:0]   din,
  input  logic [WIDTH-1:0] ipol,
  output logic [WIDTH:0]   sync,
  output logic [WIDTH-1:0] edges
);

  logic [WIDTH:0]   sync1;
  logic [WIDTH:0]   sync2;
  logic [WIDTH-1:0] prev;

  // prev follows sync2 unconditionally so direction changes never fake an edge
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2[WIDTH-1:0];
    end
  end

  assign sync  = sync2;
  assign edges = (ipol & sync2[WIDTH-1:0] & ~prev) |
                 (~ipol & ~sync2[WIDTH-1:0] & prev);

endmodule

// File: rtl/ahb_gpio_irq.sv
// rtl/ahb_gpio_irq.sv - AHB-Lite GPIO slave with direction control, parity and edge interrupts
module ahb_gpio_irq
  import ahb_gpio_pkg::*;
#(
  parameter int         GPIO_WIDTH = 16,
  parameter logic [7:0] DATA_ADDR  = DATA_OFS,
  parameter logic [7:0] DIR_ADDR   = DIR_OFS,
  parameter logic [7:0] IEN_ADDR   = IEN_OFS,
  parameter logic [7:0] IPOL_ADDR  = IPOL_OFS,
  parameter logic [7:0] ISTAT_ADDR = ISTAT_OFS
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_gpio_irq_if.slave         ahb,
  input  logic                  PARITYSEL,
  input  logic [GPIO_WIDTH:0]   GPIOIN,
  output logic [GPIO_WIDTH:0]   GPIOOUT,
  output logic [GPIO_WIDTH-1:0] GPIOEN,
  output logic                  PARITYERR,
  output logic                  IRQ
);

  localparam int W = GPIO_WIDTH;

  logic         rd_q;
  logic         wr_q;
  logic [7:0]   addr_q;
  logic         active;
  logic         wr_en;
  logic         wr_data;
  logic         wr_dir;
  logic         wr_ien;
  logic         wr_ipol;
  logic         wr_istat;

  logic [W-1:0] dir;
  logic [W:0]   ien;
  logic [W-1:0] ipol;
  logic [W:0]   istat;
  logic [W-1:0] dout;

  logic [W:0]   sync;
  logic [W-1:0] edges;
  logic [W:0]   istat_set;
  logic [W:0]   istat_clr;
  logic [31:0]  rdata;
  logic         unused_bits;

  assign active = ahb.HSEL &&
                  (ahb.HTRANS == HTRANS_NONSEQ || ahb.HTRANS == HTRANS_SEQ);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
    end else if (ahb.HREADY) begin
      rd_q   <= active;
      wr_q   <= active && ahb.HWRITE;
      addr_q <= ahb.HADDR[7:0];
    end
  end

  assign wr_en    = wr_q && ahb.HREADY;
  assign wr_data  = wr_en && (addr_q == DATA_ADDR);
  assign wr_dir   = wr_en && (addr_q == DIR_ADDR);
  assign wr_ien   = wr_en && (addr_q == IEN_ADDR);
  assign wr_ipol  = wr_en && (addr_q == IPOL_ADDR);
  assign wr_istat = wr_en && (addr_q == ISTAT_ADDR);

  gpio_sync_edge #(.WIDTH(W)) u_sync_edge (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .din     (GPIOIN),
    .ipol    (ipol),
    .sync    (sync),
    .edges   (edges)
  );

  assign PARITYERR = sync[W] != parity(32'(sync[W-1:0]), PARITYSEL);

  // output pins never raise status, whatever their pad level does
  assign istat_set = {PARITYERR, edges & ~dir};
  assign istat_clr = wr_istat ? ahb.HWDATA[W:0] : '0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dir   <= '0;
      ien   <= '0;
      ipol  <= '0;
      istat <= '0;
      dout  <= '0;
    end else begin
      if (wr_dir)  dir  <= ahb.HWDATA[W-1:0];
      if (wr_ien)  ien  <= ahb.HWDATA[W:0];
      if (wr_ipol) ipol <= ahb.HWDATA[W-1:0];
      if (wr_data) dout <= (dout & ~dir) | (ahb.HWDATA[W-1:0] & dir);
      // set is OR-ed after the clear so a coincident edge is never lost
      istat <= (istat & ~istat_clr) | istat_set;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_q) begin
      case (addr_q)
        DATA_ADDR:  rdata[W:0]   = {sync[W], (dout & dir) | (sync[W-1:0] & ~dir)};
        DIR_ADDR:   rdata[W-1:0] = dir;
        IEN_ADDR:   rdata[W:0]   = ien;
        IPOL_ADDR:  rdata[W-1:0] = ipol;
        ISTAT_ADDR: rdata[W:0]   = istat;
        default:    rdata        = '0;
      endcase
    end
  end

  assign ahb.HRDATA    = rdata;
  assign ahb.HREADYOUT = 1'b1;
  assign GPIOOUT       = {parity(32'(dout), PARITYSEL), dout};
  assign GPIOEN        = dir;
  assign IRQ           = |(istat & ien);

  assign unused_bits = ^{ahb.HADDR[31:8], ahb.HWDATA};

endmodule

// File: tb/tb_ahb_gpio_irq.sv
// tb/tb_ahb_gpio_irq.sv - randomized self-checking bench with a behavioural GPIO model
module tb_ahb_gpio_irq;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        PARITYSEL;
  logic [16:0] GPIOIN;
  logic [16:0] GPIOOUT;
  logic [15:0] GPIOEN;
  logic        PARITYERR;
  logic        IRQ;

  ahb_gpio_irq_if bus();

  ahb_gpio_irq dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .ahb       (bus),
    .PARITYSEL (PARITYSEL),
    .GPIOIN    (GPIOIN),
    .GPIOOUT   (GPIOOUT),
    .GPIOEN    (GPIOEN),
    .PARITYERR (PARITYERR),
    .IRQ       (IRQ)
  );

  always #5 HCLK = ~HCLK;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // model state: registers plus the pin history seen at the last three edges
  logic [15:0] m_dir, m_ipol, m_dout;
  logic [16:0] m_ien, m_istat;
  logic [16:0] h1, h2, h3;
  logic        p_rd, p_wr;
  logic [7:0]  p_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic par(input logic [15:0] d, input logic odd_sel);
    logic ones_odd;
    ones_odd = ($countones(d) % 2) == 1;
    return odd_sel ? ~ones_odd : ones_odd;
  endfunction

  function automatic logic [31:0] exp_rdata();
    logic [31:0] r;
    r = '0;
    if (p_rd) begin
      case (p_addr)
        8'h00: begin
          for (int i = 0; i < 16; i++) r[i] = m_dir[i] ? m_dout[i] : h2[i];
          r[16] = h2[16];
        end
        8'h04: r[15:0] = m_dir;
        8'h08: r[16:0] = m_ien;
        8'h0C: r[15:0] = m_ipol;
        8'h10: r[16:0] = m_istat;
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  task automatic model_reset();
    m_dir = '0; m_ipol = '0; m_dout = '0; m_ien = '0; m_istat = '0;
    h1 = '0; h2 = '0; h3 = '0;
    p_rd = 1'b0; p_wr = 1'b0; p_addr = '0;
  endtask

  task automatic model_step();
    logic [16:0] set_v;
    logic [16:0] clr_v;
    logic        act;
    if (!HRESETn) begin
      model_reset();
      return;
    end
    set_v = '0;
    clr_v = '0;
    for (int i = 0; i < 16; i++)
      if (!m_dir[i] && (m_ipol[i] ? (h2[i] && !h3[i]) : (!h2[i] && h3[i]))) set_v[i] = 1'b1;
    set_v[16] = h2[16] != par(h2[15:0], PARITYSEL);
    if (p_wr) begin
      case (p_addr)
        8'h00: for (int i = 0; i < 16; i++) if (m_dir[i]) m_dout[i] = bus.HWDATA[i];
        8'h04: m_dir  = bus.HWDATA[15:0];
        8'h08: m_ien  = bus.HWDATA[16:0];
        8'h0C: m_ipol = bus.HWDATA[15:0];
        8'h10: clr_v  = bus.HWDATA[16:0];
        default: ;
      endcase
    end
    m_istat = (m_istat & ~clr_v) | set_v;
    h3 = h2; h2 = h1; h1 = GPIOIN;
    act    = bus.HSEL && bus.HTRANS[1];
    p_rd   = act;
    p_wr   = act && bus.HWRITE;
    p_addr = bus.HADDR[7:0];
  endtask

  always @(negedge HCLK) begin
    if (chk_en) begin
      check("hrdata",    bus.HRDATA, exp_rdata());
      check("hreadyout", 32'(bus.HREADYOUT), 32'd1);
      check("gpioout",   32'(GPIOOUT), 32'({par(m_dout, PARITYSEL), m_dout}));
      check("gpioen",    32'(GPIOEN), 32'(m_dir));
      check("parityerr", 32'(PARITYERR), 32'(h2[16] != par(h2[15:0], PARITYSEL)));
      check("irq",       32'(IRQ), 32'(|(m_istat & m_ien)));
    end
  end

  task automatic cycle();
    @(posedge HCLK);
    model_step();
    #2;
  endtask

  task automatic idle_bus();
    bus.HSEL = 1'b0; bus.HWRITE = 1'b0; bus.HTRANS = 2'b00;
  endtask

  task automatic addr_phase(input logic [7:0] a, input logic wr);
    bus.HSEL = 1'b1; bus.HADDR = {24'h0, a}; bus.HWRITE = wr; bus.HTRANS = 2'b10;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    addr_phase(a, 1'b1);
    cycle();
    idle_bus();
    bus.HWDATA = d;
    cycle();
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    addr_phase(a, 1'b0);
    cycle();
    idle_bus();
    #3;
    d = bus.HRDATA;
    #1;
  endtask

  logic [31:0] rd;
  logic [7:0]  addrs [6];

  initial begin
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14};
    HRESETn = 1'b0; PARITYSEL = 1'b0; GPIOIN = '0;
    bus.HREADY = 1'b1; bus.HADDR = '0; bus.HWDATA = '0;
    idle_bus();
    model_reset();
    repeat (2) cycle();
    chk_en = 1'b1;
    HRESETn = 1'b1;
    cycle();

    for (int k = 0; k < 5; k++) begin
      bus_read(addrs[k], rd);
      check("reset_read", rd, 32'h0);
    end
    PARITYSEL = 1'b1;
    #1;
    check("reset_gpioout_odd", 32'(GPIOOUT), 32'h0001_0000);
    check("reset_irq", 32'(IRQ), 32'h0);
    PARITYSEL = 1'b0;

    bus_write(8'h04, 32'h0000_FFFF);
    bus_write(8'h00, 32'h0000_A5A5);
    check("gpioout_a5a5", 32'(GPIOOUT), 32'h0000_A5A5);
    bus_read(8'h00, rd);
    check("data_read_a5a5", rd, 32'h0000_A5A5);
    bus_write(8'h04, 32'h0000_00FF);
    bus_write(8'h00, 32'h0000_0000);
    check("gpioout_masked", 32'(GPIOOUT), 32'h0000_A500);

    bus_write(8'h04, 32'h0);
    bus_write(8'h08, 32'h1);
    bus_write(8'h0C, 32'h1);
    GPIOIN = 17'h1_0001;
    cycle();
    addr_phase(8'h00, 1'b0);
    cycle();
    idle_bus();
    #1;
    check("edge_data_n1", bus.HRDATA, 32'h0001_0001);
    check("edge_irq_n1", 32'(IRQ), 32'h0);
    cycle();
    #1;
    check("edge_irq_n2", 32'(IRQ), 32'h1);
    bus_read(8'h10, rd);
    check("edge_istat", rd, 32'h1);
    bus_write(8'h10, 32'h1);
    #1;
    check("istat_clear_irq", 32'(IRQ), 32'h0);

    bus_write(8'h08, 32'h9);
    GPIOIN = 17'h0_0009;
    repeat (4) cycle();
    bus_read(8'h10, rd);
    check("wrong_pol_none", rd, 32'h0);
    GPIOIN = 17'h1_0001;
    repeat (4) cycle();
    bus_read(8'h10, rd);
    check("fall_bit3", rd, 32'h8);
    check("fall_bit3_irq", 32'(IRQ), 32'h1);
    bus_write(8'h10, 32'h8);
    GPIOIN = 17'h0_0021;
    repeat (4) cycle();
    GPIOIN = 17'h1_0001;
    repeat (4) cycle();
    bus_read(8'h10, rd);
    check("masked_bit5_stat", rd, 32'h20);
    check("masked_bit5_irq", 32'(IRQ), 32'h0);
    bus_write(8'h10, 32'h20);

    GPIOIN = 17'h1_0000;
    cycle();
    cycle();
    #1;
    check("parerr_set", 32'(PARITYERR), 32'h1);
    bus_read(8'h10, rd);
    check("parerr_istat", rd, 32'h1_0000);
    bus_write(8'h08, 32'h1_0001);
    check("parerr_irq", 32'(IRQ), 32'h1);
    GPIOIN = 17'h0_0000;
    repeat (3) cycle();
    check("parerr_clear", 32'(PARITYERR), 32'h0);
    bus_read(8'h10, rd);
    check("parerr_sticky", rd, 32'h1_0000);
    bus_write(8'h10, 32'h1_0000);
    bus_read(8'h10, rd);
    check("parerr_w1c", rd, 32'h0);

    GPIOIN = 17'h1_0001;
    cycle();
    addr_phase(8'h10, 1'b1);
    cycle();
    idle_bus();
    bus.HWDATA = 32'h1;
    cycle();
    #1;
    check("set_wins_irq", 32'(IRQ), 32'h1);
    bus_read(8'h10, rd);
    check("set_wins_istat", rd, 32'h1);

    addr_phase(8'h04, 1'b1);
    cycle();
    idle_bus();
    bus.HWDATA = 32'h0000_FFFF;
    #1;
    HRESETn = 1'b0;
    model_reset();
    cycle();
    check("rst_gpioen", 32'(GPIOEN), 32'h0);
    HRESETn = 1'b1;
    cycle();
    bus_read(8'h04, rd);
    check("rst_dir", rd, 32'h0);
    bus_read(8'h10, rd);
    check("rst_istat", rd, 32'h0);
    check("rst_gpioout", 32'(GPIOOUT), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      bus.HSEL   = ($urandom_range(0, 3) != 0);
      bus.HADDR  = {$urandom_range(0, 255) == 0 ? 24'hABCDEF : 24'h0, addrs[$urandom_range(0, 5)]};
      bus.HWRITE = $urandom_range(0, 1) == 1;
      bus.HTRANS = 2'($urandom_range(0, 3));
      bus.HWDATA = $urandom();
      if ($urandom_range(0, 3) == 0) begin
        GPIOIN = GPIOIN ^ (17'h1 << $urandom_range(0, 15));
        if ($urandom_range(0, 2) != 0)
          GPIOIN[16] = par(GPIOIN[15:0], PARITYSEL);
      end
      if ($urandom_range(0, 31) == 0) PARITYSEL = ~PARITYSEL;
      cycle();
    end
    idle_bus();
    repeat (3) cycle();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
